// File: rtl/mem_io_bridge.sv
// -----------------------------------------------------------------------------
// mem_io_bridge
//
// Bridge between the CPU core (MAR/MDR side) and an external asynchronous
// SRAM plus one memory-mapped board I/O word.
//
// - CPU side: level request, one-cycle completion pulse (cpu_ack). The
//   request is only looked at while the bridge is idle.
// - SRAM side: a SETUP cycle, WAIT_STATES ACCESS cycles and a DONE cycle.
//   Every strobe comes straight from a flop.
// - I/O word at IO_ADDR: reads return the switches and writes update the
//   hex-display register. Both complete in a single IO_DONE cycle and never
//   touch the SRAM strobes.
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   cpu_req/we/be/addr    CPU request, direction, byte enables, word address
//   cpu_wdata             CPU write data
//   cpu_rdata             registered read data; held until the next ack
//   cpu_ack               one-cycle completion pulse
//   busy                  high whenever the FSM is not idle
//   sram_addr/ce_n/oe_n/  SRAM address and active-low strobes
//   we_n/be_n
//   sram_wdata/drive      data toward the tristate buffer and its enable
//   sram_rdata            data from the tristate buffer
//   switches              board switches (the I/O read source)
//   hex_out               display nibbles; nibble k = hex_out[4k+3:4k]
// -----------------------------------------------------------------------------
module mem_io_bridge #(
    parameter int                    DATA_W      = 16,
    parameter int                    CPU_ADDR_W  = 16,
    parameter int                    SRAM_ADDR_W = 20,
    parameter int                    WAIT_STATES = 1,
    parameter int                    NUM_HEX     = 4,
    parameter int                    SW_W        = 16,
    parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                     Clk,
    input  logic                     Reset,
    // CPU side
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [DATA_W/8-1:0]      cpu_be,
    input  logic [CPU_ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_ack,
    output logic                     busy,
    // SRAM side
    output logic [SRAM_ADDR_W-1:0]   sram_addr,
    output logic                     sram_ce_n,
    output logic                     sram_oe_n,
    output logic                     sram_we_n,
    output logic [DATA_W/8-1:0]      sram_be_n,
    output logic [DATA_W-1:0]        sram_wdata,
    output logic                     sram_drive,
    input  logic [DATA_W-1:0]        sram_rdata,
    // Board I/O
    input  logic [SW_W-1:0]          switches,
    output logic [NUM_HEX*4-1:0]     hex_out
);

    localparam int BE_W  = DATA_W / 8;
    localparam int HEX_W = NUM_HEX * 4;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES - 1);

    // -------------------------------------------------------------------------
    // Parameter legality, checked during elaboration
    // -------------------------------------------------------------------------
    generate
        if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("mem_io_bridge: WAIT_STATES must be in 1..15");
        end
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
            $error("mem_io_bridge: DATA_W must be a non-zero multiple of 8");
        end
        if (HEX_W > DATA_W || NUM_HEX < 1) begin : g_bad_num_hex
            $error("mem_io_bridge: NUM_HEX*4 must fit inside DATA_W");
        end
        if (SRAM_ADDR_W < CPU_ADDR_W) begin : g_bad_sram_addr_w
            $error("mem_io_bridge: SRAM_ADDR_W must be >= CPU_ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE,
        S_IO_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                   state_q;
    logic [CNT_W-1:0]         wait_cnt_q;
    logic                     we_q;          // direction of the access in flight
    logic [DATA_W-1:0]        cpu_rdata_q;
    logic                     cpu_ack_q;
    logic                     busy_q;
    logic [SRAM_ADDR_W-1:0]   sram_addr_q;
    logic                     sram_ce_n_q;
    logic                     sram_oe_n_q;
    logic                     sram_we_n_q;
    logic [BE_W-1:0]          sram_be_n_q;
    logic [DATA_W-1:0]        sram_wdata_q;
    logic                     sram_drive_q;
    logic [HEX_W-1:0]         hex_q;

    // -------------------------------------------------------------------------
    // Request decode (combinational, used only in IDLE)
    // -------------------------------------------------------------------------
    logic                     io_hit_d;
    logic [SRAM_ADDR_W-1:0]   sram_addr_d;
    logic [DATA_W-1:0]        sw_ext_d;
    logic [HEX_W-1:0]         hex_wmask_d;
    logic [HEX_W-1:0]         hex_d;

    assign io_hit_d    = (cpu_addr == IO_ADDR);
    assign sram_addr_d = SRAM_ADDR_W'(cpu_addr);  // zero-extend
    assign sw_ext_d    = DATA_W'(switches);       // zero-extend or truncate

    // Each display bit is written when the byte lane containing it is enabled.
    // Lanes that lie entirely above the display width have no effect.
    genvar gi;
    generate
        for (gi = 0; gi < HEX_W; gi++) begin : g_hex_mask
            assign hex_wmask_d[gi] = cpu_be[gi/8];
        end
    endgenerate

    assign hex_d = (hex_q & ~hex_wmask_d) | (cpu_wdata[HEX_W-1:0] & hex_wmask_d);

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    //
    // Every output flop is loaded on the edge that enters the state in which
    // the value must be visible. That is why the SRAM address and strobes are
    // set while leaving IDLE, and cpu_ack/cpu_rdata are set while leaving the
    // last ACCESS cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            we_q         <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
            sram_addr_q  <= '0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            sram_be_n_q  <= '1;
            sram_wdata_q <= '0;
            sram_drive_q <= 1'b0;
            hex_q        <= '0;
        end else begin
            cpu_ack_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q   <= cpu_we;
                        busy_q <= 1'b1;
                        if (io_hit_d) begin
                            // The I/O word completes in one cycle, so the ack
                            // and the data/display update are all issued now.
                            state_q   <= S_IO_DONE;
                            cpu_ack_q <= 1'b1;
                            if (cpu_we) begin
                                hex_q <= hex_d;
                            end else begin
                                cpu_rdata_q <= sw_ext_d;
                            end
                        end else begin
                            state_q     <= S_SETUP;
                            sram_addr_q <= sram_addr_d;
                            sram_ce_n_q <= 1'b0;
                            sram_be_n_q <= ~cpu_be;
                            sram_oe_n_q <= cpu_we;   // output enable for reads only
                            sram_drive_q <= cpu_we;  // drive the bus for writes only
                            if (cpu_we) begin
                                sram_wdata_q <= cpu_wdata;
                            end
                        end
                    end
                end

                S_SETUP: begin
                    state_q    <= S_ACCESS;
                    wait_cnt_q <= WS_LOAD;
                    if (we_q) begin
                        sram_we_n_q <= 1'b0;
                    end
                end

                S_ACCESS: begin
                    if (wait_cnt_q == '0) begin
                        state_q     <= S_DONE;
                        cpu_ack_q   <= 1'b1;
                        sram_we_n_q <= 1'b1;
                        sram_oe_n_q <= 1'b1;
                        if (!we_q) begin
                            // The SRAM data is stable by the end of the last
                            // ACCESS cycle. A read needs no hold time, so the
                            // chip is released together with oe_n.
                            cpu_rdata_q <= sram_rdata;
                            sram_ce_n_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end

                S_DONE: begin
                    // A write keeps ce_n, drive and data through DONE for
                    // hold time, then releases everything here.
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    sram_ce_n_q  <= 1'b1;
                    sram_drive_q <= 1'b0;
                    sram_be_n_q  <= '1;
                end

                S_IO_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign busy       = busy_q;
    assign sram_addr  = sram_addr_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_be_n  = sram_be_n_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_drive = sram_drive_q;
    assign hex_out    = hex_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_io_bridge
//
// Bench for mem_io_bridge with WAIT_STATES=2 and a behavioural byte-lane SRAM
// model. Hand-written cycle-by-cycle sequences cover the timing corners. A
// vector table run through a scoreboard covers the data paths.
// -----------------------------------------------------------------------------
module tb_mem_io_bridge;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int SAW = 20;
    localparam int WS  = 2;
    localparam int NH  = 4;
    localparam int SWW = 16;
    localparam int SRAM_LAT = 2 + WS;

    logic            clk;
    logic            rst;
    logic            cpu_req;
    logic            cpu_we;
    logic [1:0]      cpu_be;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_ack;
    logic            busy;
    logic [SAW-1:0]  sram_addr;
    logic            sram_ce_n;
    logic            sram_oe_n;
    logic            sram_we_n;
    logic [1:0]      sram_be_n;
    logic [DW-1:0]   sram_wdata;
    logic            sram_drive;
    logic [DW-1:0]   sram_rdata;
    logic [SWW-1:0]  switches;
    logic [NH*4-1:0] hex_out;

    mem_io_bridge #(
        .DATA_W      (DW),
        .CPU_ADDR_W  (AW),
        .SRAM_ADDR_W (SAW),
        .WAIT_STATES (WS),
        .NUM_HEX     (NH),
        .SW_W        (SWW),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n),
        .sram_wdata (sram_wdata),
        .sram_drive (sram_drive),
        .sram_rdata (sram_rdata),
        .switches   (switches),
        .hex_out    (hex_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Async SRAM model: byte-lane writes while ce_n/we_n are low, data out
    // while ce_n/oe_n are low.
    // -------------------------------------------------------------------------
    logic [15:0] mem [0:65535];
    logic        model_init;

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
            mem[16'h0040] <= 16'h1234;
            mem[16'hFFFE] <= 16'hA5A5;
        end else if (!sram_ce_n && !sram_we_n && sram_drive) begin
            if (!sram_be_n[0]) mem[sram_addr[15:0]][7:0]  <= sram_wdata[7:0];
            if (!sram_be_n[1]) mem[sram_addr[15:0]][15:8] <= sram_wdata[15:8];
        end
    end

    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[15:0]] : 16'h0000;

    // -------------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard entry: pushed when a request is driven, popped at cpu_ack.
    typedef struct {
        bit          is_read;
        logic [15:0] rdata;
        logic [15:0] hex;
        int          lat;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        bit          we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_rdata;
        logic [15:0] exp_hex;
    } vec_t;

    task automatic run_vec(input vec_t v);
        sb_t e;
        int  cyc;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_be    = v.be;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        switches  = v.sw;
        e.is_read = !v.we;
        e.rdata   = v.exp_rdata;
        e.hex     = v.exp_hex;
        e.lat     = (v.addr == 16'hFFFF) ? 1 : SRAM_LAT;
        sb_q.push_back(e);
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 1;
        while (cpu_ack !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (cpu_ack !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL %s ack_timeout: got no ack, expected ack within 40 cycles", v.name);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk({v.name, " latency"}, 32'(cyc), 32'(e.lat));
            if (e.is_read) chk({v.name, " rdata"}, 32'(cpu_rdata), 32'(e.rdata));
            chk({v.name, " hex_out"}, 32'(hex_out), 32'(e.hex));
            $display("txn %-12s we=%0b be=%b addr=%h wdata=%h -> ack@%0d rdata=%h hex=%h",
                     v.name, v.we, v.be, v.addr, v.wdata, cyc, cpu_rdata, hex_out);
        end
        @(negedge clk);
        chk({v.name, " busy_after"}, 32'(busy), 32'(0));
    endtask

    vec_t vecs[13];
    int   ack_cnt;
    int   ack_c1;
    int   ack_c2;

    initial begin
        // Vector table (expected values follow from the hand sequences below,
        // which leave 0x0100 = 0x00EF and hex_out cleared by the mid-op reset).
        vecs[0]  = '{"rd100",    1'b0, 2'b11, 16'h0100, 16'h0000, 16'h0000, 16'h00EF, 16'h0000};
        vecs[1]  = '{"wr100_hi", 1'b1, 2'b10, 16'h0100, 16'h1200, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{"rd100b",   1'b0, 2'b11, 16'h0100, 16'h0000, 16'h0000, 16'h12EF, 16'h0000};
        vecs[3]  = '{"wr200_be0",1'b1, 2'b00, 16'h0200, 16'h5678, 16'h0000, 16'h0000, 16'h0000};
        vecs[4]  = '{"rd200",    1'b0, 2'b00, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[5]  = '{"rdFFFE",   1'b0, 2'b01, 16'hFFFE, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
        vecs[6]  = '{"io_wr11",  1'b1, 2'b11, 16'hFFFF, 16'hCAFE, 16'h0000, 16'h0000, 16'hCAFE};
        vecs[7]  = '{"io_wr01",  1'b1, 2'b01, 16'hFFFF, 16'h0012, 16'h0000, 16'h0000, 16'hCA12};
        vecs[8]  = '{"io_wr10",  1'b1, 2'b10, 16'hFFFF, 16'h3400, 16'h0000, 16'h0000, 16'h3412};
        vecs[9]  = '{"io_wr00",  1'b1, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h3412};
        vecs[10] = '{"io_rd",    1'b0, 2'b11, 16'hFFFF, 16'h0000, 16'h8001, 16'h8001, 16'h3412};
        vecs[11] = '{"wr040",    1'b1, 2'b11, 16'h0040, 16'hBBAA, 16'h0000, 16'h0000, 16'h3412};
        vecs[12] = '{"rd040",    1'b0, 2'b11, 16'h0040, 16'h0000, 16'h0000, 16'hBBAA, 16'h3412};

        rst = 1'b1; model_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00;
        cpu_addr = '0; cpu_wdata = '0; switches = '0;
        repeat (3) @(negedge clk);
        model_init = 1'b0;

        // ---------------- reset state ----------------
        chk("rst cpu_ack",   32'(cpu_ack),    32'(0));
        chk("rst cpu_rdata", 32'(cpu_rdata),  32'(0));
        chk("rst busy",      32'(busy),       32'(0));
        chk("rst sram_addr", 32'(sram_addr),  32'(0));
        chk("rst strobes",   32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(3'b111));
        chk("rst be_n",      32'(sram_be_n),  32'(2'b11));
        chk("rst wdata",     32'(sram_wdata), 32'(0));
        chk("rst drive",     32'(sram_drive), 32'(0));
        chk("rst hex",       32'(hex_out),    32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'(0));

        // ---------------- SRAM read 0x0040, cycle by cycle ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 16'h0040;
        @(negedge clk); cpu_req = 1'b0; cpu_addr = 16'h0123;          // cycle 1
        chk("rd c1 ce/oe",  32'({sram_ce_n, sram_oe_n}), 32'(2'b00));
        chk("rd c1 we_n",   32'(sram_we_n), 32'(1));
        chk("rd c1 drive",  32'(sram_drive), 32'(0));
        chk("rd c1 addr",   32'(sram_addr), 32'(20'h00040));
        chk("rd c1 busy",   32'(busy), 32'(1));
        @(negedge clk);                                                // cycle 2
        chk("rd c2 ce/oe",  32'({sram_ce_n, sram_oe_n}), 32'(2'b00));
        chk("rd c2 ack",    32'(cpu_ack), 32'(0));
        @(negedge clk);                                                // cycle 3
        chk("rd c3 ce/oe",  32'({sram_ce_n, sram_oe_n}), 32'(2'b00));
        chk("rd c3 ack",    32'(cpu_ack), 32'(0));
        @(negedge clk);                                                // cycle 4
        chk("rd c4 ack",    32'(cpu_ack), 32'(1));
        chk("rd c4 rdata",  32'(cpu_rdata), 32'(16'h1234));
        chk("rd c4 oe_n",   32'(sram_oe_n), 32'(1));
        @(negedge clk);                                                // cycle 5
        chk("rd c5 ack",    32'(cpu_ack), 32'(0));
        chk("rd c5 busy",   32'(busy), 32'(0));
        chk("rd c5 held",   32'(cpu_rdata), 32'(16'h1234));

        // ---------------- SRAM write 0xBEEF to 0x0100, be=01 ----------------
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b01; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
        @(negedge clk); cpu_req = 1'b0; cpu_be = 2'b11; cpu_wdata = 16'h0000;  // cycle 1
        chk("wr c1 ce/oe/we", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'(3'b011));
        chk("wr c1 drive",    32'(sram_drive), 32'(1));
        chk("wr c1 be_n",     32'(sram_be_n), 32'(2'b10));
        chk("wr c1 wdata",    32'(sram_wdata), 32'(16'hBEEF));
        @(negedge clk);                                                // cycle 2
        chk("wr c2 we_n",     32'(sram_we_n), 32'(0));
        @(negedge clk);                                                // cycle 3
        chk("wr c3 we_n",     32'(sram_we_n), 32'(0));
        chk("wr c3 drive",    32'(sram_drive), 32'(1));
        @(negedge clk);                                                // cycle 4
        chk("wr c4 ack",      32'(cpu_ack), 32'(1));
        chk("wr c4 we_n",     32'(sram_we_n), 32'(1));
        chk("wr c4 drive",    32'(sram_drive), 32'(1));
        chk("wr c4 wdata",    32'(sram_wdata), 32'(16'hBEEF));
        @(negedge clk);                                                // cycle 5
        chk("wr c5 drive",    32'(sram_drive), 32'(0));
        chk("wr c5 ce_n",     32'(sram_ce_n), 32'(1));
        chk("wr mem lanes",   32'(mem[16'h0100]), 32'(16'h00EF));

        // ---------------- I/O write 0xCAFE ----------------
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'hFFFF; cpu_wdata = 16'hCAFE;
        @(negedge clk); cpu_req = 1'b0;                                // cycle 1
        chk("iow c1 ack",  32'(cpu_ack), 32'(1));
        chk("iow c1 hex",  32'(hex_out), 32'(16'hCAFE));
        chk("iow c1 ce_n", 32'(sram_ce_n), 32'(1));
        chk("iow c1 we_n", 32'(sram_we_n), 32'(1));
        @(negedge clk);                                                // cycle 2
        chk("iow c2 ack",  32'(cpu_ack), 32'(0));
        chk("iow c2 busy", 32'(busy), 32'(0));
        chk("iow c2 ce_n", 32'(sram_ce_n), 32'(1));

        // ---------------- I/O read switches ----------------
        switches = 16'h00A5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFF;
        @(negedge clk); cpu_req = 1'b0;                                // cycle 1
        chk("ior c1 ack",   32'(cpu_ack), 32'(1));
        chk("ior c1 rdata", 32'(cpu_rdata), 32'(16'h00A5));
        chk("ior c1 ce_n",  32'(sram_ce_n), 32'(1));
        @(negedge clk);

        // ---------------- back-to-back reads, req held ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 16'h0040;
        ack_cnt = 0; ack_c1 = 0; ack_c2 = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 6) cpu_req = 1'b0;
            if (cpu_ack === 1'b1) begin
                ack_cnt++;
                if (ack_cnt == 1) ack_c1 = c; else ack_c2 = c;
            end
            if (c == 5) chk("b2b c5 ce_n", 32'(sram_ce_n), 32'(1));
            if (c == 6) chk("b2b c6 ce_n", 32'(sram_ce_n), 32'(0));
        end
        chk("b2b ack count",  32'(ack_cnt), 32'(2));
        chk("b2b first ack",  32'(ack_c1), 32'(4));
        chk("b2b second ack", 32'(ack_c2), 32'(9));

        // ---------------- req pulses while busy ----------------
        cpu_req = 1'b1; cpu_addr = 16'h0040;
        ack_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            cpu_req = (c == 2 || c == 4);
            if (cpu_ack === 1'b1) ack_cnt++;
        end
        chk("busy pulses ack count", 32'(ack_cnt), 32'(1));

        // ---------------- reset during ACCESS of a write ----------------
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'h0300; cpu_wdata = 16'h1111;
        @(negedge clk); cpu_req = 1'b0;                                // cycle 1
        @(negedge clk);                                                // cycle 2 (ACCESS)
        chk("rstmid c2 we_n", 32'(sram_we_n), 32'(0));
        rst = 1'b1;
        @(negedge clk);                                                // cycle 3
        chk("rstmid we/ce",  32'({sram_we_n, sram_ce_n}), 32'(2'b11));
        chk("rstmid drive",  32'(sram_drive), 32'(0));
        chk("rstmid ack",    32'(cpu_ack), 32'(0));
        chk("rstmid busy",   32'(busy), 32'(0));
        chk("rstmid hex",    32'(hex_out), 32'(0));
        rst = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) ack_cnt++;
        end
        chk("rstmid no ack", 32'(ack_cnt), 32'(0));

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
